// File: rtl/link_rx.sv
// link_rx: 8E1 serial receiver for the board-to-board game link.
// Samples the peer's transmit line, deserializes start / 8 data (LSB first) /
// even parity / stop frames and holds each byte behind a valid/ack handshake.
//
// Ports:
//   clock       system clock (100 MHz)
//   reset_n     asynchronous active-low reset
//   rx          serial line from the peer, idles high, asynchronous to clock
//   rx_data     held received byte
//   rx_valid    an unconsumed byte is held
//   rx_ack      consumer pulse; clears rx_valid, parity_err and overrun
//   parity_err  held byte failed even parity (meaningful while rx_valid)
//   frame_err   one-cycle pulse when a frame is dropped for a low stop bit
//   overrun     sticky: a frame completed while rx_valid was still high
//   busy        receiver FSM is not idle
module link_rx #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          expired;
  logic          commit, bad_stop;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      par   <= par_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    par_n    = par;
    commit   = 1'b0;
    bad_stop = 1'b0;
    expired  = (cnt == '0);

    // Count down only while framing; the counter parks at zero otherwise.
    if (state != IDLE && !expired)
      cnt_n = cnt - CW'(1);

    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_LOAD;
          state_n = START;
        end
      end
      START: begin
        if (expired) begin
          if (rx_s) begin
            state_n = IDLE;            // line bounced back high: glitch
          end else begin
            state_n = DATA;
            idx_n   = '0;
            cnt_n   = FULL_LOAD;
          end
        end
      end
      DATA: begin
        if (expired) begin
          shift_n[idx] = rx_s;
          cnt_n        = FULL_LOAD;
          if (idx == 3'd7)
            state_n = PARITY;
          else
            idx_n = idx + 3'd1;
        end
      end
      PARITY: begin
        if (expired) begin
          par_n   = rx_s;
          cnt_n   = FULL_LOAD;
          state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (expired) begin
          state_n = IDLE;
          if (rx_s)
            commit = 1'b1;
          else
            bad_stop = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      busy      <= (state_n != IDLE);
      if (commit && (!rx_valid || rx_ack)) begin
        // An ack landing on the commit cycle frees the holding slot.
        rx_data    <= shift;
        parity_err <= ^shift ^ par;
        rx_valid   <= 1'b1;
        if (rx_ack)
          overrun <= 1'b0;
      end else if (commit) begin
        overrun <= 1'b1;
      end else if (rx_ack) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_link_rx.sv
module tb_link_rx;

  localparam int unsigned CPB = 16;

  logic       clock;
  logic       reset_n;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  link_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;
  int   valid_cyc = 0;
  int   fe_count = 0;
  int   byte_count = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    rx = p;
    repeat (CPB) @(negedge clock);
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic do_ack(input string name);
    @(negedge clock);
    rx_ack = 1'b1;
    @(negedge clock);
    rx_ack = 1'b0;
    check({name, "_valid_after_ack"}, rx_valid, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Scoreboard monitor: a byte is presented when rx_valid rises, or stays
  // high across an ack (commit and ack in the same cycle).
  initial begin : monitor
    logic prev_valid;
    int   fe_len;
    exp_t e;
    prev_valid = 1'b0;
    fe_len = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        prev_valid = 1'b0;
        fe_len = 0;
      end else begin
        if (rx_valid && (!prev_valid || rx_ack)) begin
          byte_count++;
          valid_cyc = cyc;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
          end else begin
            e = sb.pop_front();
            check("rx_data", rx_data, e.d);
            check("parity_err", parity_err, e.pe);
          end
        end
        if (frame_err) begin
          fe_len++;
        end else if (fe_len > 0) begin
          check("frame_err_width", fe_len, 1);
          fe_count++;
          fe_len = 0;
        end
        prev_valid = rx_valid;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   fe_before;
    logic busy_seen;

    reset_n = 1'b0;
    rx      = 1'b1;
    rx_ack  = 1'b0;
    idle(3);
    check("reset_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 0);
    reset_n = 1'b1;
    idle(5);

    // 0xA5: even parity bit 0, latency check.
    sb.push_back('{d: 8'hA5, pe: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_valid", rx_valid, 1);
    check("a5_latency_ok", ((valid_cyc - fall_cyc) >= 170) && ((valid_cyc - fall_cyc) <= 172), 1);
    check("a5_no_frame_err", fe_count, 0);
    do_ack("a5");
    idle(5);

    // 4-cycle low glitch.
    busy_seen = 1'b0;
    @(negedge clock);
    rx = 1'b0;
    repeat (4) begin
      @(negedge clock);
      busy_seen |= busy;
    end
    rx = 1'b1;
    repeat (30) begin
      @(negedge clock);
      busy_seen |= busy;
    end
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_idle", busy, 0);
    check("glitch_no_valid", rx_valid, 0);
    check("glitch_no_frame_err", fe_count, 0);

    // 0x3C with wrong parity, then correct parity.
    sb.push_back('{d: 8'h3C, pe: 1'b1});
    send_frame(8'h3C, 1'b1, 1'b1);
    check("3c_bad_par_valid", rx_valid, 1);
    do_ack("3c_bad");
    check("3c_par_cleared", parity_err, 0);
    sb.push_back('{d: 8'h3C, pe: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1);
    check("3c_good_valid", rx_valid, 1);
    do_ack("3c_good");

    // 0x5A with stop bit 0, then 0x11.
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(40);
    check("5a_frame_err_count", fe_count, 1);
    check("5a_no_valid", rx_valid, 0);
    sb.push_back('{d: 8'h11, pe: 1'b0});
    send_frame(8'h11, 1'b0, 1'b1);
    check("11_valid", rx_valid, 1);
    do_ack("11");

    // Back-to-back without ack: overrun, first byte kept.
    sb.push_back('{d: 8'h01, pe: 1'b0});
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    check("ovr_data_kept", rx_data, 8'h01);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", rx_valid, 1);
    do_ack("ovr");
    check("ovr_cleared", overrun, 0);

    // Back-to-back with ack landing on the second commit cycle.
    sb.push_back('{d: 8'h01, pe: 1'b0});
    send_frame(8'h01, 1'b1, 1'b1);
    sb.push_back('{d: 8'h02, pe: 1'b0});
    fork
      send_frame(8'h02, 1'b1, 1'b1);
      begin
        @(negedge clock);
        repeat (170) @(negedge clock);
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
      end
    join
    check("ackcommit_data", rx_data, 8'h02);
    check("ackcommit_valid", rx_valid, 1);
    check("ackcommit_overrun", overrun, 0);
    do_ack("ackcommit");

    // Asynchronous reset in the middle of 0xFF.
    fork
      send_frame(8'hFF, 1'b0, 1'b1);
      begin
        @(negedge clock);
        repeat (60) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midframe_reset_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun, busy}, 0);
      end
    join
    idle(3);
    reset_n = 1'b1;
    idle(20);
    check("post_reset_idle", {rx_valid, busy}, 0);
    sb.push_back('{d: 8'h7E, pe: 1'b0});
    send_frame(8'h7E, 1'b0, 1'b1);
    check("7e_valid", rx_valid, 1);
    do_ack("7e");

    idle(10);
    check("scoreboard_drained", sb.size(), 0);
    check("bytes_delivered", byte_count, 8);
    check("frame_err_total", fe_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
